spram_sf_buf: RTL and testbench



---
 rtl/spram_sf_buf_pkg.sv | 20 ++
 rtl/sf_skid_fifo.sv | 88 ++++++++
 rtl/spram_sf_buf.sv | 253 +++++++++++++++++++++++++
 tb/tb_spram_sf_buf.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_sf_buf_pkg.sv
// -----------------------------------------------------------------------------
// spram_sf_buf_pkg
// Shared types and helpers for the store-and-forward frame buffer.
//   state_t    : controller state (FILL, DRAIN, DROP)
//   skid_depth : number of output skid entries needed to hide a RAM read
//                latency of rd_lat cycles at full throughput
// -----------------------------------------------------------------------------
package spram_sf_buf_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DROP  = 2'd2
    } state_t;

    function automatic int skid_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/sf_skid_fifo.sv
// -----------------------------------------------------------------------------
// sf_skid_fifo
// Small register FIFO that absorbs RAM read data while the downstream
// consumer stalls. The caller guarantees it never pushes into a full FIFO
// (reads are only issued against free credit), so no overflow guard here.
//
// Parameters:
//   WIDTH : entry width (data + last tag)
//   DEPTH : number of entries (>= 1)
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_push        : write i_push_data at the tail
//   i_push_data   : entry to write
//   i_pop         : drop the head entry
//   o_head        : current head entry (valid when !o_empty)
//   o_count       : number of stored entries
//   o_empty       : FIFO holds no entries
// -----------------------------------------------------------------------------
module sf_skid_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PW-1:0]    r_wr_idx;
    logic [PW-1:0]    r_rd_idx;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wr_idx_inc;
    logic [PW-1:0]    w_rd_idx_inc;

    // Index wrap is explicit so DEPTH need not be a power of two.
    assign w_wr_idx_inc = (r_wr_idx == PW'(DEPTH - 1)) ? '0 : r_wr_idx + 1'b1;
    assign w_rd_idx_inc = (r_rd_idx == PW'(DEPTH - 1)) ? '0 : r_rd_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_idx <= w_wr_idx_inc;
            end
            if (i_pop) begin
                r_rd_idx <= w_rd_idx_inc;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload registers carry no reset; occupancy alone decides validity.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (i_push && (r_wr_idx == PW'(gi))) begin
                    r_mem[gi] <= i_push_data;
                end
            end
        end

        if (DEPTH == 1) begin : g_head_single
            assign o_head = r_mem[0];
        end else begin : g_head_mux
            assign o_head = r_mem[r_rd_idx];
        end
    endgenerate

    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/spram_sf_buf.sv
// -----------------------------------------------------------------------------
// spram_sf_buf
// Store-and-forward frame buffer in front of a single-port RAM. A whole frame
// is written into the RAM from the input stream (FILL), then read back to the
// output stream (DRAIN). Fill and drain never overlap because the RAM has a
// single port, which this block owns exclusively.
//
// Build option:
//   SPRAM_SF_BUF_OVF_DROP_EN : when defined, an input frame longer than DEPTH
//     words is truncated: the word at DEPTH-1 is stored as last, the excess
//     is discarded in DROP until s_last, and sticky err_ovf is raised.
//     When undefined, an oversize frame is split into several frames.
//
// Parameters:
//   DWIDTH : data word width (matches the RAM)
//   AWIDTH : RAM address width, DEPTH = 1 << AWIDTH
//   RD_LAT : RAM read latency, 1 (registered output) or 0 (combinational)
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input stream
//   m_valid/m_ready/m_data/m_last : output stream
//   ram_we/ram_addr/ram_data : RAM write enable, address, write data
//   ram_q                    : RAM read data
//   err_ovf                  : sticky overflow flag (option only)
// -----------------------------------------------------------------------------
module spram_sf_buf
    import spram_sf_buf_pkg::*;
#(
    parameter int DWIDTH = 128,
    parameter int AWIDTH = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_q
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
    ,
    output logic              err_ovf
`endif
);

    localparam int DEPTH      = 1 << AWIDTH;
    localparam int SKID_DEPTH = skid_depth(RD_LAT);
    localparam int CW         = $clog2(SKID_DEPTH + 1);

    state_t            r_state;
    state_t            w_state_next;

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_len;
    // One extra bit so the pointer can step past len = DEPTH-1 without
    // wrapping back into the readable range.
    logic [AWIDTH:0]   r_rd_ptr;

    logic              w_s_accept;
    logic              w_fill_end;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_credit_ok;
    logic [CW:0]       w_credit_used;
    logic              w_inflight;
    logic              w_push;
    logic              w_push_last;
    logic              w_pop;
    logic              w_skid_empty;
    logic [CW-1:0]     w_skid_count;
    logic [DWIDTH:0]   w_skid_head;

    // ---------------------------------------------------------------- input
    assign w_s_accept = s_valid & s_ready;
    assign w_fill_end = (r_state == FILL) & w_s_accept
                      & (s_last | (r_wr_ptr == AWIDTH'(DEPTH - 1)));
    assign ram_data   = s_data;

    // ----------------------------------------------------------- read issue
    // A word popped this cycle frees its slot immediately, which keeps the
    // drain at one word per cycle when m_ready stays high.
    assign w_credit_used = (CW + 1)'(w_skid_count) + (CW + 1)'(w_inflight)
                         - (CW + 1)'(w_pop);
    assign w_credit_ok   = (w_credit_used < (CW + 1)'(SKID_DEPTH));
    assign w_issue_last  = (r_rd_ptr == {1'b0, r_len});
    assign w_issue       = (r_state == DRAIN)
                         & (r_rd_ptr <= {1'b0, r_len})
                         & w_credit_ok;

    // The last tag travels alongside the read so it lands with its data.
    generate
        if (RD_LAT == 0) begin : g_rd_comb
            assign w_push      = w_issue;
            assign w_push_last = w_issue_last;
            assign w_inflight  = 1'b0;
        end else begin : g_rd_reg
            logic r_rd_vld;
            logic r_rd_last;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_vld  <= 1'b0;
                    r_rd_last <= 1'b0;
                end else begin
                    r_rd_vld  <= w_issue;
                    r_rd_last <= w_issue_last;
                end
            end

            assign w_push      = r_rd_vld;
            assign w_push_last = r_rd_last;
            assign w_inflight  = r_rd_vld;
        end
    endgenerate

    // ------------------------------------------------------------ skid FIFO
    sf_skid_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (SKID_DEPTH),
        .CW    (CW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({w_push_last, ram_q}),
        .i_pop       (w_pop),
        .o_head      (w_skid_head),
        .o_count     (w_skid_count),
        .o_empty     (w_skid_empty)
    );

    assign m_valid = ~w_skid_empty;
    assign m_data  = w_skid_head[DWIDTH-1:0];
    assign m_last  = w_skid_head[DWIDTH];
    assign w_pop   = m_valid & m_ready;

    // ------------------------------------------------------ state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_fill_end) begin
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
                    // Filling the last slot without s_last means the frame
                    // is too long: swallow the rest of it.
                    w_state_next = s_last ? DRAIN : DROP;
`else
                    w_state_next = DRAIN;
`endif
                end
            end
            DRAIN: begin
                if (w_pop && m_last) begin
                    w_state_next = FILL;
                end
            end
            DROP: begin
                if (w_s_accept && s_last) begin
                    w_state_next = DRAIN;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // s_ready is held low while rst is asserted even though the state
    // register already shows FILL.
    always_comb begin
        s_ready  = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        case (r_state)
            FILL: begin
                s_ready  = ~rst;
                ram_we   = s_valid & ~rst;
                ram_addr = r_wr_ptr;
            end
            DRAIN: begin
                ram_addr = r_rd_ptr[AWIDTH-1:0];
            end
            DROP: begin
                s_ready  = ~rst;
            end
            default: begin
                s_ready  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------- pointers and length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_len    <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_s_accept) begin
                        if (w_fill_end) begin
                            r_len    <= r_wr_ptr;
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_issue) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                default: begin
                    r_rd_ptr <= r_rd_ptr;
                end
            endcase
        end
    end

`ifdef SPRAM_SF_BUF_OVF_DROP_EN
    // --------------------------------------------------- overflow flag
    logic r_err_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
        end else if ((r_state == DROP) && w_s_accept) begin
            r_err_ovf <= 1'b1;
        end
    end

    assign err_ovf = r_err_ovf;
`endif

endmodule

// File: tb/tb_spram_sf_buf.sv
// -----------------------------------------------------------------------------
// tb_spram_sf_buf
// Self-checking bench for spram_sf_buf with a behavioural single-port RAM.
// Expected output words are pushed to a queue as input words are accepted
// (splitting or dropping oversize frames as the build option dictates) and
// compared against every output handshake.
// Build option honoured: SPRAM_SF_BUF_OVF_DROP_EN.
// -----------------------------------------------------------------------------
module tb_spram_sf_buf;

    localparam int DW     = 128;
    localparam int AW     = 2;
    localparam int DEPTH  = 1 << AW;
    parameter  int RD_LAT = 1;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
    logic          err_ovf;
`endif

    spram_sf_buf #(
        .DWIDTH (DW),
        .AWIDTH (AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_q    (ram_q)
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
        ,
        .err_ovf  (err_ovf)
`endif
    );

    // ------------------------------------------------------------ RAM model
    logic [DW-1:0] ram_mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
    end

    generate
        if (RD_LAT == 0) begin : g_ram_comb
            assign ram_q = ram_mem[ram_addr];
        end else begin : g_ram_reg
            logic [DW-1:0] ram_q_r;
            always @(posedge clk) ram_q_r <= ram_mem[ram_addr];
            assign ram_q = ram_q_r;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ----------------------------------------------------------- bookkeeping
    int             n_checks = 0;
    int             n_fail   = 0;
    int             pop_cnt  = 0;
    int             rdy_mode = 0;
    int             pat_i    = 0;
    logic [5:0]     rdy_pat  = 6'b101001; // bit0 first: 1,0,0,1,0,1
    logic [DW:0]    exp_q [$];
    int             fill_idx = 0;
    bit             dropping = 0;
    bit             chk_rdy_next = 0;

    task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkword(input logic [7:0] tag, input int i);
        return {4{tag, i[23:0]}};
    endfunction

    // Downstream ready pattern, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = rdy_pat[pat_i];
                pat_i   = (pat_i + 1) % 6;
            end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: each handshake is compared against the scoreboard.
    always @(negedge clk) begin
        if (chk_rdy_next) begin
            chk_rdy_next = 0;
            if (!rst) chk("s_ready_after_last_pop", s_ready, 1);
        end
        if (!rst && m_valid && m_ready) begin
            logic [DW:0] e;
            bit          have;
            have = (exp_q.size() != 0);
            chk("out_expected", have, 1);
            $display("out data=%h last=%0d", m_data, m_last);
            if (have) begin
                e = exp_q.pop_front();
                chk("m_data", m_data, e[DW-1:0]);
                chk("m_last", m_last, e[DW]);
            end
            pop_cnt++;
            if (m_last) chk_rdy_next = 1;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one input word; checks the RAM write side and updates the model.
    task automatic send_word(input logic [DW-1:0] d, input logic l);
        bit ok = 0;
        bit exp_we;
        bit last_eff;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("s_ready_timeout", s_ready, 1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
        end
        exp_we = !dropping;
        chk("ram_we", ram_we, exp_we);
        if (exp_we) begin
            chk("ram_addr", ram_addr, fill_idx);
            chk("ram_data", ram_data, d);
        end
        $display("in  data=%h last=%0d", d, l);
        if (dropping) begin
            if (l) dropping = 0;
        end else begin
            last_eff = l || (fill_idx == DEPTH - 1);
            exp_q.push_back({last_eff, d});
            if (last_eff) begin
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
                if (!l) dropping = 1;
`endif
                fill_idx = 0;
            end else begin
                fill_idx++;
            end
        end
        sync();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called right after the final input word's accept edge.
    task automatic check_latency(input string tag);
        for (int k = 0; k <= RD_LAT; k++) begin
            @(negedge clk);
            chk({tag, "_mvalid_early"}, m_valid, 0);
            if (k == 0) chk({tag, "_s_ready_low"}, s_ready, 0);
        end
        @(negedge clk);
        chk({tag, "_mvalid_first"}, m_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_drain_timeout"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk({tag, "_idle_mvalid"}, m_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bit ok;
        int n;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
        chk("rst_err_ovf", err_ovf, 0);
`endif
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1);

        // Basic 4-word frame, m_ready held high
        rdy_mode = 0;
        sync();
        for (int i = 0; i < 4; i++) send_word(mkword(8'hA0, i), i == 3);
        check_latency("basic");
        wait_idle("basic");
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
        chk("exact_depth_err_ovf", err_ovf, 0);
`endif

        // Backpressure pattern
        rdy_mode = 1;
        sync();
        for (int i = 0; i < 4; i++) send_word(mkword(8'hA1, i), i == 3);
        wait_idle("bp");

        // Single-word frame
        rdy_mode = 0;
        sync();
        send_word(mkword(8'hB0, 0), 1'b1);
        check_latency("single");
        wait_idle("single");

        // Oversize frame C0..C5
        sync();
        for (int i = 0; i < 6; i++) send_word(mkword(8'hC0, i), i == 5);
        wait_idle("oversize");
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
        chk("oversize_err_ovf", err_ovf, 1);
`endif

        // Random frames under random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 4);
            sync();
            for (int i = 0; i < n; i++) send_word({4{$urandom()}}, i == n - 1);
        end
        wait_idle("random");

        // Reset in the middle of a drain
        rdy_mode = 0;
        base = pop_cnt;
        sync();
        for (int i = 0; i < 4; i++) send_word(mkword(8'hE0, i), i == 3);
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (pop_cnt >= base + 2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("mid_drain_timeout", pop_cnt - base, 2);
        #1;
        rst = 1'b1;
        exp_q.delete();
        fill_idx = 0;
        dropping = 0;
        @(negedge clk);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_ram_we", ram_we, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_m_valid", m_valid, 0);
`ifdef SPRAM_SF_BUF_OVF_DROP_EN
        chk("post_rst_err_ovf", err_ovf, 0);
`endif
        sync();
        send_word(mkword(8'hD0, 0), 1'b1);
        wait_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
